// File: rtl/angle_spi_pkg.sv
// Shared constants and FSM state encoding for the angle-sensor SPI scheduler.
package angle_spi_pkg;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned ANGLE_BITS  = 14;
  localparam int unsigned PARITY_BIT  = 15;
  localparam int unsigned ERRFLAG_BIT = 14;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSelect = 3'd1;
  localparam state_t StShift  = 3'd2;
  localparam state_t StHold   = 3'd3;
  localparam state_t StGap    = 3'd4;

endpackage

// File: rtl/spi_frame_shifter.sv
// One SPI mode-1 frame: sck divider, bit counter, command shift-out and response shift-in.
module spi_frame_shifter
  import angle_spi_pkg::*;
#(
  parameter int unsigned            CLK_DIV  = 25,
  parameter logic [FRAME_BITS-1:0]  CMD_WORD = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx
);

  localparam int unsigned DivW = $clog2(2 * CLK_DIV);

  logic                  active_q;
  logic [DivW-1:0]       div_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] rx_q;
  logic                  period_end;
  logic                  falling;

  // Each sck period starts high; the falling edge lands after CLK_DIV cycles.
  assign period_end = active_q && (div_q == DivW'(2 * CLK_DIV - 1));
  assign falling    = active_q && (div_q == DivW'(CLK_DIV - 1));
  assign done       = period_end && (bit_q == 4'(FRAME_BITS - 1));
  assign sck        = active_q && (div_q < DivW'(CLK_DIV));
  assign mosi       = tx_q[FRAME_BITS-1];
  assign rx         = rx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= CMD_WORD;
      rx_q     <= '0;
    end else if (active_q) begin
      if (falling) begin
        rx_q <= {rx_q[FRAME_BITS-2:0], miso};
      end
      if (period_end) begin
        div_q <= '0;
        if (done) begin
          active_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 4'd1;
          tx_q  <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/angle_spi_scheduler.sv
// Round-robin scan of up to eight SPI angle sensors sharing one bus; emits angle results.
module angle_spi_scheduler
  import angle_spi_pkg::*;
#(
  parameter int unsigned           NUM_SENSORS = 8,
  parameter int unsigned           CLK_DIV     = 25,
  parameter int unsigned           GAP_CYCLES  = 20,
  parameter logic [FRAME_BITS-1:0] CMD_WORD    = 16'hFFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic                   angle_miso,
  output logic                   angle_mosi,
  output logic                   angle_sck,
  output logic [NUM_SENSORS-1:0] angle_ss_n_o,
  output logic                   result_valid,
  output logic [2:0]             result_index,
  output logic [ANGLE_BITS-1:0]  result_angle,
  output logic                   result_error,
  output logic                   sweep_done,
  output logic                   busy
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  state_t                state_q, state_d;
  logic [2:0]            index_q, index_d;
  logic [CntW-1:0]       cyc_q, cyc_d;
  logic                  start, done, res_fire, in_frame;
  logic                  sh_sck, sh_mosi;
  logic [FRAME_BITS-1:0] rx;
  logic [NUM_SENSORS-1:0] mask_above;
  logic                  has_above;
  logic [2:0]            next_index;

  function automatic logic [2:0] lowest_set(input logic [NUM_SENSORS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  always_comb begin
    mask_above = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      mask_above[i] = sensor_mask[i] && (i > int'(index_q));
    end
    has_above  = |mask_above;
    next_index = has_above ? lowest_set(mask_above) : lowest_set(sensor_mask);
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cyc_d    = cyc_q + CntW'(1);
    start    = 1'b0;
    res_fire = 1'b0;
    case (state_q)
      StIdle: begin
        cyc_d = '0;
        if (enable && (|sensor_mask)) begin
          state_d = StSelect;
          index_d = lowest_set(sensor_mask);
        end
      end
      StSelect: begin
        if (cyc_q == CntW'(CLK_DIV - 1)) begin
          state_d = StShift;
          start   = 1'b1;
          cyc_d   = '0;
        end
      end
      StShift: begin
        cyc_d = '0;
        if (done) state_d = StHold;
      end
      StHold: begin
        if (cyc_q == CntW'(CLK_DIV - 1)) begin
          state_d  = StGap;
          cyc_d    = '0;
          res_fire = 1'b1;
        end
      end
      StGap: begin
        if (cyc_q == CntW'(GAP_CYCLES - 1)) begin
          cyc_d = '0;
          if (enable && (|sensor_mask)) begin
            state_d = StSelect;
            index_d = next_index;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cyc_q   <= cyc_d;
    end
  end

  // Result fields are captured as HOLD ends so they appear on the first GAP cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;
      result_index <= '0;
      result_angle <= '0;
      result_error <= 1'b0;
    end else begin
      result_valid <= res_fire;
      sweep_done   <= res_fire && !has_above;
      if (res_fire) begin
        result_index <= index_q;
        result_angle <= rx[ANGLE_BITS-1:0];
        result_error <= (^rx[PARITY_BIT:0]) | rx[ERRFLAG_BIT];
      end
    end
  end

  spi_frame_shifter #(
    .CLK_DIV  (CLK_DIV),
    .CMD_WORD (CMD_WORD)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .start (start),
    .miso  (angle_miso),
    .sck   (sh_sck),
    .mosi  (sh_mosi),
    .done  (done),
    .rx    (rx)
  );

  always_comb begin
    in_frame = (state_q == StSelect) || (state_q == StShift) || (state_q == StHold);
    for (int i = 0; i < NUM_SENSORS; i++) begin
      angle_ss_n_o[i] = !(in_frame && (index_q == 3'(i)));
    end
    angle_sck = sh_sck;
    if (state_q == StSelect)     angle_mosi = CMD_WORD[FRAME_BITS-1];
    else if (state_q == StShift) angle_mosi = sh_mosi;
    else                         angle_mosi = 1'b0;
    busy = (state_q != StIdle);
  end

endmodule

// File: tb/tb_angle_spi_scheduler.sv
// Bench for angle_spi_scheduler: sensor model on the bus plus a frame-level reference model.
module tb_angle_spi_scheduler;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam logic [15:0] CMD        = 16'hA53C;
  localparam int          FRAME      = 34 * CLK_DIV + GAP_CYCLES;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic        angle_miso = 1'b0;
  logic        angle_mosi, angle_sck, result_valid, result_error, sweep_done, busy;
  logic [7:0]  angle_ss_n_o;
  logic [2:0]  result_index;
  logic [13:0] result_angle;

  logic [15:0] resp [8];
  logic [15:0] cur_word = '0;
  int          bitk = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  angle_spi_scheduler #(
    .NUM_SENSORS (8),
    .CLK_DIV     (CLK_DIV),
    .GAP_CYCLES  (GAP_CYCLES),
    .CMD_WORD    (CMD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sensor_mask  (mask),
    .angle_miso   (angle_miso),
    .angle_mosi   (angle_mosi),
    .angle_sck    (angle_sck),
    .angle_ss_n_o (angle_ss_n_o),
    .result_valid (result_valid),
    .result_index (result_index),
    .result_angle (result_angle),
    .result_error (result_error),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  wire sel_all = &angle_ss_n_o;

  // Mode-1 sensor: loads its word on select, presents the next bit on each sck rise.
  always @(negedge sel_all or posedge angle_sck) begin
    if (angle_sck) begin
      if (bitk < 16) angle_miso <= cur_word[15 - bitk];
      bitk <= bitk + 1;
    end else begin
      for (int i = 0; i < 8; i++) if (!angle_ss_n_o[i]) cur_word <= resp[i];
      bitk <= 0;
    end
  end

  function automatic int model_next(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  function automatic logic model_err(input logic [15:0] w);
    return (($countones(w) % 2) == 1) || w[14];
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    mask   = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_result(output logic [2:0] idx, output logic [13:0] ang, output logic er,
                             output logic sw, output int t, output bit ok);
    idx = '0; ang = '0; er = 1'b0; sw = 1'b0; t = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (result_valid) begin
        idx = result_index; ang = result_angle; er = result_error; sw = sweep_done;
        t = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  // Collects nres results and compares each against the round-robin reference model.
  task automatic check_sequence(input string tag, input logic [7:0] m, input int nres);
    logic [2:0] idx; logic [13:0] ang; logic er, sw; int t, prev_t, exp; bit ok;
    logic [15:0] w; logic [13:0] exp_ang; logic [17:0] got, want;
    exp = model_next(m, 7);
    prev_t = -1;
    for (int r = 0; r < nres; r++) begin
      wait_result(idx, ang, er, sw, t, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL %s timeout: no result_valid, wanted result %0d", tag, r);
        return;
      end
      w = resp[exp];
      exp_ang = w[13:0];
      want = {3'(exp), exp_ang, model_err(w)};
      got  = {idx, ang, er};
      if (got !== want) $display("FAIL %s result %0d: got idx/ang/err %h want %h", tag, r, got, want);
      else n_pass++;
      n_checks++;
      if (sw !== (model_next(m, exp) <= exp))
        $display("FAIL %s sweep_done %0d: got %b want %b", tag, r, sw, model_next(m, exp) <= exp);
      else n_pass++;
      if (prev_t >= 0) begin
        n_checks++;
        if (t - prev_t != FRAME)
          $display("FAIL %s spacing %0d: got %0d want %0d", tag, r, t - prev_t, FRAME);
        else n_pass++;
      end
      prev_t = t;
      exp = model_next(m, exp);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1; mask = 8'h01;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({angle_ss_n_o, angle_sck, angle_mosi, result_valid, sweep_done, busy} !== {8'hFF, 5'b0})
      $display("FAIL reset outputs: got %h %b%b%b%b%b want ff 00000", angle_ss_n_o, angle_sck,
               angle_mosi, result_valid, sweep_done, busy);
    else n_pass++;
    n_checks++;
    if ({result_index, result_angle, result_error} !== 18'h0)
      $display("FAIL reset result fields: got %h want 0", {result_index, result_angle, result_error});
    else n_pass++;
    reset = 1'b0;
    enable = 1'b0;
    mask = 8'h00;
  endtask

  task automatic test_idle_mask0();
    bit stayed = 1'b1;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy || angle_ss_n_o != 8'hFF || result_valid) stayed = 1'b0;
    end
    n_checks++;
    if (!stayed) $display("FAIL mask0 idle: got activity want idle");
    else n_pass++;
    mask = 8'h01;
    @(negedge clock);
    n_checks++;
    if ({busy, angle_ss_n_o} !== {1'b1, 8'hFE})
      $display("FAIL idle to select: got busy %b ss %h want 1 fe", busy, angle_ss_n_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    resp[0] = 16'h3FFF; resp[2] = 16'h0003;
    mask = 8'h05; enable = 1'b1;
    check_sequence("rr05", 8'h05, 4);
    do_reset();
  endtask

  task automatic test_errors();
    logic [2:0] idx; logic [13:0] ang; logic er, sw; int t; bit ok;
    do_reset();
    resp[0] = 16'h0001;
    mask = 8'h01; enable = 1'b1;
    wait_result(idx, ang, er, sw, t, ok);
    resp[0] = 16'hC000;
    n_checks++;
    if ({ok, ang, er} !== {1'b1, 14'h0001, 1'b1})
      $display("FAIL parity error: got ok %b ang %h err %b want 1 0001 1", ok, ang, er);
    else n_pass++;
    wait_result(idx, ang, er, sw, t, ok);
    n_checks++;
    if ({ok, ang, er} !== {1'b1, 14'h0000, 1'b1})
      $display("FAIL flag error: got ok %b ang %h err %b want 1 0000 1", ok, ang, er);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_frame_shape();
    int t_sel = -1, t_sck = -1, t_val = -1, rises = 0;
    logic [15:0] cap = '0;
    logic prev_sck = 1'b0;
    bit ss_ok = 1'b1;
    do_reset();
    resp[3] = 16'($urandom);
    mask = 8'h08; enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (t_sel < 0 && angle_ss_n_o != 8'hFF) t_sel = cyc;
      if (t_sel >= 0 && t_val < 0) begin
        if (result_valid) t_val = cyc;
        else begin
          if (angle_ss_n_o != 8'hF7) ss_ok = 1'b0;
          if (angle_sck && !prev_sck) begin
            rises++;
            cap = {cap[14:0], angle_mosi};
            if (t_sck < 0) t_sck = cyc;
          end
        end
      end
      prev_sck = angle_sck;
      if (t_val >= 0) break;
    end
    enable = 1'b0;
    n_checks++;
    if (rises != 16) $display("FAIL sck rises: got %0d want 16", rises);
    else n_pass++;
    n_checks++;
    if (cap !== CMD) $display("FAIL mosi capture: got %h want %h", cap, CMD);
    else n_pass++;
    n_checks++;
    if (!ss_ok) $display("FAIL select pattern: got other than f7 want f7");
    else n_pass++;
    n_checks++;
    if (t_sck - t_sel != 2) $display("FAIL select to sck: got %0d want 2", t_sck - t_sel);
    else n_pass++;
    n_checks++;
    if (t_val - t_sel != 34 * CLK_DIV)
      $display("FAIL select to valid: got %0d want %0d", t_val - t_sel, 34 * CLK_DIV);
    else n_pass++;
    n_checks++;
    if (result_angle !== resp[3][13:0])
      $display("FAIL shape angle: got %h want %h", result_angle, resp[3][13:0]);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      m = 8'($urandom_range(1, 255));
      for (int i = 0; i < 8; i++) resp[i] = 16'($urandom);
      mask = m; enable = 1'b1;
      check_sequence("random", m, 6);
    end
    do_reset();
  endtask

  task automatic test_enable_drop();
    logic [2:0] idx; logic [13:0] ang; logic er, sw; int t; bit ok; bit quiet = 1'b1;
    do_reset();
    resp[0] = 16'h1234; resp[2] = 16'h0F0F;
    mask = 8'h05; enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (angle_sck) break;
    end
    enable = 1'b0;
    wait_result(idx, ang, er, sw, t, ok);
    n_checks++;
    if ({ok, idx, ang} !== {1'b1, 3'd0, 14'h1234})
      $display("FAIL drop result: got ok %b idx %0d ang %h want 1 0 1234", ok, idx, ang);
    else n_pass++;
    repeat (3) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL drop gap busy: got %b want 1", busy);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL drop idle busy: got %b want 0", busy);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy || angle_ss_n_o != 8'hFF) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL drop stays idle: got activity want idle");
    else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [2:0] idx; logic [13:0] ang; logic er, sw; int t; bit ok;
    do_reset();
    resp[1] = 16'h0505; resp[2] = 16'h0A0A;
    mask = 8'h06; enable = 1'b1;
    wait_result(idx, ang, er, sw, t, ok);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (angle_ss_n_o == 8'hFB) break;
    end
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({angle_ss_n_o, angle_sck, result_valid, busy} !== {8'hFF, 3'b000})
      $display("FAIL mid reset: got ss %h sck %b valid %b busy %b want ff 0 0 0", angle_ss_n_o,
               angle_sck, result_valid, busy);
    else n_pass++;
    reset = 1'b0;
    wait_result(idx, ang, er, sw, t, ok);
    n_checks++;
    if ({ok, idx, ang} !== {1'b1, 3'd1, 14'h0505})
      $display("FAIL restart index: got ok %b idx %0d ang %h want 1 1 0505", ok, idx, ang);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_sensor();
    do_reset();
    resp[7] = 16'h2AAA;
    mask = 8'h80; enable = 1'b1;
    check_sequence("single80", 8'h80, 3);
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 16'h0000;
    test_reset();
    test_idle_mask0();
    test_round_robin();
    test_errors();
    test_frame_shape();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_single_sensor();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/angle_spi_scheduler.md
# angle_spi_scheduler

Round-robin scheduler that shares the single angle-sensor SPI bus (one sck/mosi/miso, eight active-low selects) among up to eight magnetic angle sensors of the platform controller. It repeatedly selects each enabled sensor, shifts one 16-bit read frame, checks parity and the sensor error flag, and streams the 14-bit angle with its sensor index to the control/Avalon register side. It sits between the platform controller's register file and the angle-sensor conduit pins.

## Interface

Parameters:
- NUM_SENSORS, 8: number of select lines; index width is 3.
- CLK_DIV, 25: clock cycles per sck half-period; must be ≥1.
- GAP_CYCLES, 20: cycles all selects stay high between frames; must be ≥1.
- CMD_WORD, 16'hFFFF: word shifted out on mosi every frame (read angle register).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- enable  in  1  scan enable.
- sensor_mask  in  NUM_SENSORS  bit i set = sensor i is scanned.
- angle_miso  in  1  serial data from the selected sensor.
- angle_mosi  out  1  serial command data.
- angle_sck  out  1  SPI clock, CPOL=0.
- angle_ss_n_o  out  NUM_SENSORS  active-low selects, at most one low.
- result_valid  out  1  one-cycle pulse, result fields valid.
- result_index  out  3  sensor index of the result.
- result_angle  out  14  received bits [13:0].
- result_error  out  1  parity mismatch or sensor error flag.
- sweep_done  out  1  one-cycle pulse on the last result of a sweep.
- busy  out  1  high in any state other than IDLE.

## Operation

- SPI mode 1: mosi updates on sck rising edge (first bit driven at select), miso sampled on sck falling edge; MSB first, 16 bits.
- States: IDLE, SELECT, SHIFT, HOLD, GAP.
- IDLE: selects high, sck low, mosi low. If enable=1 and sensor_mask≠0, latch the lowest set mask bit as current index and go to SELECT.
- SELECT: ss_n[index] low, mosi=CMD_WORD[15]; CLK_DIV cycles, then SHIFT.
- SHIFT: 16 sck periods of 2·CLK_DIV cycles, sck high during the first half. At each falling edge, shift miso into the receive register; at each rising edge after the first, drive the next CMD_WORD bit. After the 16th falling edge, go to HOLD.
- HOLD: sck low, select still low; CLK_DIV cycles, then GAP.
- GAP: all selects high for GAP_CYCLES. On the first GAP cycle:
  - result_valid=1, result_index=index, result_angle=rx[13:0].
  - result_error = (^rx) | rx[14], using even parity over all 16 bits.
- Next index: lowest set bit of the current sensor_mask above index, wrapping to the lowest set bit. sweep_done=1 with result_valid when no set bit lies above index.
- GAP exit: if enable=1 and the mask is nonzero, go to SELECT with the next index, else go to IDLE.
- Mask changes take effect only at IDLE or GAP exit. An in-progress frame always completes, including on enable deassert or when its mask bit is cleared.
- result_* fields hold their value until the next result_valid.

## Timing

- Reset values: state IDLE, angle_ss_n_o all ones, angle_sck 0, angle_mosi 0, result_valid 0, sweep_done 0, busy 0, result_index/angle/error 0.
- Reset mid-frame: select released and sck low on the first clock edge with reset high. No result is emitted.
- Frame period: CLK_DIV + 32·CLK_DIV + CLK_DIV + GAP_CYCLES = 34·CLK_DIV + GAP_CYCLES cycles.
- result_valid fires 34·CLK_DIV cycles after SELECT entry.
- IDLE→SELECT takes 1 cycle after enable and a nonzero mask are seen.
- Single enabled sensor: the same index repeats, and sweep_done fires on every result.

## Structure

- Package angle_spi_pkg: state enum, FRAME_BITS=16, ANGLE_BITS=14, PARITY_BIT=15, ERRFLAG_BIT=14.
- Sub-module spi_frame_shifter: divider, bit counter, and shift registers for one frame, with a start/done handshake.
- The scheduler owns the FSM, mask arbitration, and result formatting.

## Test plan

All scenarios use CLK_DIV=2 and GAP_CYCLES=4, giving a 72-cycle frame.

- mask=8'h05, sensor0 returns 16'h3FFF, sensor2 returns 16'h0003:
  - Results alternate index0 angle 3FFF err0 / index2 angle 0003 err0.
  - Results are 72 cycles apart; sweep_done fires only with index2.
- Sensor returns 16'h0001 → angle 0001, err1 (parity). Sensor returns 16'hC000 → angle 0000, err1 (error flag).
- mosi capture over one frame equals CMD_WORD. Exactly 16 sck rising edges occur. Only ss_n[index] is low; select-to-first-sck is 2 cycles.
- Deassert enable mid-SHIFT → frame completes, result emitted, IDLE after 4 GAP cycles, busy=0.
- Assert reset in cycle 20 of a frame → next cycle selects all high, sck 0, no result_valid. Scan restarts from the lowest mask bit.
- mask=8'h80 → index 7 every frame, sweep_done on each. mask=0 with enable=1 → remains IDLE.
